prog_freq_divider: RTL
======================

# prog_freq_divider

Runtime-programmable integer clock divider for the PLL feedback path: divides `clk` by N (2..2^WIDTH-1) and produces either a near-50% square output or a single-cycle pulse. Ratio and mode changes are staged in a shadow register and take effect only at a period boundary, so the feedback clock never glitches while the loop is retuned. It supersedes the fixed free-running 4-bit divide counter.

## Interface

Parameters:
- `WIDTH`, 8: width of counter and ratio.
- `DEFAULT_DIV`, 8: ratio active out of reset; must satisfy 2 <= DEFAULT_DIV <= 2^WIDTH-1.

Ports:
- `clk`  in  1  divider input clock; all flops on rising edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `en`  in  1  count enable; 0 freezes divider state.
- `div_ratio`  in  WIDTH  requested divide ratio N.
- `div_mode`  in  1  requested output mode: 0 = square, 1 = pulse.
- `div_load`  in  1  one-cycle strobe; captures `div_ratio`/`div_mode`.
- `clk_out`  out  1  registered divided output.
- `tc`  out  1  terminal-count flag, high while count == N-1 and `en` = 1.
- `count`  out  WIDTH  current counter value.
- `active_div`  out  WIDTH  ratio currently in effect.
- `active_mode`  out  1  mode currently in effect.
- `div_pend`  out  1  staged setting waiting for the next period boundary.

## Operation

- Counter runs 0, 1, ..., N-1, 0, ... with N = `active_div`; advances one step per cycle with `en` = 1.
- `tc` = (`count` == `active_div`-1) & `en`, decoded from registers (no input-to-output path other than `en`).
- Square mode: `clk_out` is a flop whose value in every cycle equals (`count` < ceil(N/2)); high ceil(N/2) cycles, low floor(N/2) cycles. The implementation computes it from the next count value so it is never decoded combinationally.
- Pulse mode: `clk_out` is a flop whose value in every cycle equals (`count` == N-1); one cycle high per period.
- Load: on a `div_load` edge, ratio is clamped (values 0 and 1 become 2) and stored with `div_mode` into shadow; `div_pend` <= 1.
- Apply: on the edge where `tc` = 1, `count` <= 0; if pending, `active_div`/`active_mode` <= shadow and `div_pend` <= 0.
- `div_load` in the same cycle as `tc`: new value goes straight to active at that edge; `div_pend` stays 0.
- `div_load` while already pending: shadow overwritten (last write wins); `div_pend` stays 1.
- `en` = 0: `count`, `clk_out`, active and shadow settings hold; `tc` = 0; `div_load` is still captured into shadow; application waits for the next `tc`.
- Reset (asynchronous, any time, including mid-period or with a load pending): `count` = 0, `active_div` = DEFAULT_DIV, `active_mode` = 0, shadow = DEFAULT_DIV/0, `div_pend` = 0, `clk_out` = 1, `tc` = 0. The pending setting is discarded.

## Timing

- First rising edge after `rstn` release with `en` = 1: `count` 0 -> 1.
- With `en` held high, output period is exactly N `clk` cycles. Phase is continuous across ratio changes: the new period starts at `count` = 0 after the boundary.
- Load latency: the setting is visible on `active_*` the edge after the cycle in which `tc` is high. Worst case is the remaining cycles of the current period plus one.
- `clk_out` changes only on `clk` rising edges; no glitches at mode or ratio switch.
- Width: `count` compare uses WIDTH bits; `active_div`-1 never underflows because N >= 2.

## Test plan

- Reset, N = 8 default, `en` = 1: `clk_out` alternates 4 high / 4 low; `tc` high at `count` = 7 every 8 cycles; `div_pend` = 0.
- Load N = 5, square, mid-period at `count` = 3: `div_pend` = 1 until the `tc` at `count` = 7. Then `active_div` = 5 and the output runs 3 high / 2 low, period 5.
- Load N = 0, then N = 1: `active_div` becomes 2 after the boundary; `clk_out` toggles every cycle. Load N = 255, pulse mode: one-cycle `clk_out` every 255 cycles.
- `div_load` coincident with `tc` (N = 6 -> 3): the next period is 3 with no pending phase. Two loads (4 then 7) before a boundary: 7 is applied.
- Deassert `en` for 10 cycles at `count` = 2: `count`/`clk_out` frozen and `tc` = 0 throughout. Resumes at 3 with the period otherwise unchanged.
- Assert `rstn` = 0 asynchronously mid-period with a load pending: outputs take reset values immediately without waiting for a clock edge. After release, N = 8 and `div_pend` = 0.

Source files
------------

// File: rtl/prog_freq_divider_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// prog_freq_divider_if : control/status bundle of the programmable divider
// Rev 1.0
// ---------------------------------------------------------------------------
interface prog_freq_divider_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic [WIDTH-1:0] div_ratio;
  logic             div_mode;
  logic             div_load;
  logic             clk_out;
  logic             tc;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] active_div;
  logic             active_mode;
  logic             div_pend;

  modport master (
    output en, div_ratio, div_mode, div_load,
    input  clk_out, tc, count, active_div, active_mode, div_pend
  );

  modport slave (
    input  en, div_ratio, div_mode, div_load,
    output clk_out, tc, count, active_div, active_mode, div_pend
  );
endinterface
`default_nettype wire

// File: rtl/prog_freq_divider.sv
`default_nettype none
// ---------------------------------------------------------------------------
// prog_freq_divider : runtime-programmable integer divider, glitch-free retune
// Rev 1.0
// ---------------------------------------------------------------------------
module prog_freq_divider #(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 8
) (
  input  wire logic          clk,
  input  wire logic          rstn,
  prog_freq_divider_if.slave bus
);

  localparam logic [WIDTH-1:0] c_default_div = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] c_one         = WIDTH'(1);
  localparam logic [WIDTH-1:0] c_two         = WIDTH'(2);

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] active_div_q, active_div_d;
  logic             active_mode_q, active_mode_d;
  logic [WIDTH-1:0] shadow_div_q, shadow_div_d;
  logic             shadow_mode_q, shadow_mode_d;
  logic             pend_q, pend_d;
  logic             clk_out_q, clk_out_d;

  logic             w_tc;
  logic [WIDTH-1:0] w_ratio;
  logic [WIDTH-1:0] w_half;

  always_comb begin
    w_tc          = bus.en && (count_q == (active_div_q - c_one));
    w_ratio       = (bus.div_ratio < c_two) ? c_two : bus.div_ratio;
    count_d       = count_q;
    active_div_d  = active_div_q;
    active_mode_d = active_mode_q;
    shadow_div_d  = shadow_div_q;
    shadow_mode_d = shadow_mode_q;
    pend_d        = pend_q;
    clk_out_d     = clk_out_q;

    if (w_tc) begin
      // Period boundary: a coincident load bypasses the shadow stage.
      count_d = '0;
      if (bus.div_load) begin
        active_div_d  = w_ratio;
        active_mode_d = bus.div_mode;
        shadow_div_d  = w_ratio;
        shadow_mode_d = bus.div_mode;
        pend_d        = 1'b0;
      end else if (pend_q) begin
        active_div_d  = shadow_div_q;
        active_mode_d = shadow_mode_q;
        pend_d        = 1'b0;
      end
    end else begin
      if (bus.en) begin
        count_d = count_q + c_one;
      end
      if (bus.div_load) begin
        shadow_div_d  = w_ratio;
        shadow_mode_d = bus.div_mode;
        pend_d        = 1'b1;
      end
    end

    // ceil(N/2) without needing an extra bit for N+1.
    w_half = (active_div_d >> 1) + {{(WIDTH-1){1'b0}}, active_div_d[0]};
    if (bus.en) begin
      clk_out_d = active_mode_d ? (count_d == (active_div_d - c_one))
                                : (count_d < w_half);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_q       <= '0;
      active_div_q  <= c_default_div;
      active_mode_q <= 1'b0;
      shadow_div_q  <= c_default_div;
      shadow_mode_q <= 1'b0;
      pend_q        <= 1'b0;
      clk_out_q     <= 1'b1;
    end else begin
      count_q       <= count_d;
      active_div_q  <= active_div_d;
      active_mode_q <= active_mode_d;
      shadow_div_q  <= shadow_div_d;
      shadow_mode_q <= shadow_mode_d;
      pend_q        <= pend_d;
      clk_out_q     <= clk_out_d;
    end
  end

  assign bus.tc          = w_tc;
  assign bus.clk_out     = clk_out_q;
  assign bus.count       = count_q;
  assign bus.active_div  = active_div_q;
  assign bus.active_mode = active_mode_q;
  assign bus.div_pend    = pend_q;

endmodule
`default_nettype wire
